// File: rtl/glyph_blit_engine.sv
// Character-cell blitter: captures one glyph cell on start and writes it into the
// SRAM framebuffer pixel by pixel, row-major, over a valid/ack write handshake.
module glyph_blit_engine #(
    parameter int GLYPH_W    = 8,
    parameter int GLYPH_H    = 16,
    parameter int COLOR_W    = 8,
    parameter int ADDR_W     = 20,
    parameter int ROW_STRIDE = 640
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          base_addr,
    input  logic [GLYPH_W*GLYPH_H-1:0] shape,
    input  logic [COLOR_W-1:0]         fg,
    input  logic [COLOR_W-1:0]         bg,
    input  logic                       attr_inverse,
    input  logic                       attr_underline,
    input  logic                       attr_blank,
    output logic                       req_valid,
    output logic [ADDR_W-1:0]          req_addr,
    output logic [COLOR_W-1:0]         req_data,
    input  logic                       req_ack,
    output logic                       busy,
    output logic                       done
);

    localparam int NPIX = GLYPH_W * GLYPH_H;
    localparam int XW   = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
    localparam int YW   = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
    localparam int IW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(GLYPH_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(GLYPH_H - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [XW-1:0]       r_x;
    logic [YW-1:0]       r_y;
    logic [ADDR_W-1:0]   r_base;
    logic [NPIX-1:0]     r_shape;
    logic [COLOR_W-1:0]  r_fg;
    logic [COLOR_W-1:0]  r_bg;
    logic                r_inverse;
    logic                r_underline;
    logic                r_blank;

    logic                w_accept;
    logic                w_advance;
    logic [IW-1:0]       w_bitIdx;
    logic                w_on;
    logic [COLOR_W-1:0]  w_color;
    logic [ADDR_W-1:0]   w_addr;

    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_advance = (r_state == S_WRITE) && req_ack;

    // Address arithmetic is done in ADDR_W bits so it wraps modulo the SRAM size.
    assign w_bitIdx = IW'(r_y) * IW'(GLYPH_W) + IW'(r_x);
    assign w_on     = ~r_blank & (r_shape[w_bitIdx] | (r_underline & (r_y == Y_LAST)));
    assign w_color  = (w_on ^ r_inverse) ? r_fg : r_bg;
    assign w_addr   = r_base + ADDR_W'(r_y) * ADDR_W'(ROW_STRIDE) + ADDR_W'(r_x);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        req_valid   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        req_addr    = '0;
        req_data    = '0;
        case (r_state)
            S_IDLE: begin
                if (start) w_nextState = S_WRITE;
            end
            S_WRITE: begin
                req_valid = 1'b1;
                busy      = 1'b1;
                req_addr  = w_addr;
                req_data  = w_color;
                if (req_ack && (r_x == X_LAST) && (r_y == Y_LAST)) w_nextState = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Operands are frozen at start so the scanner may move on to the next cell.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x         <= '0;
            r_y         <= '0;
            r_base      <= '0;
            r_shape     <= '0;
            r_fg        <= '0;
            r_bg        <= '0;
            r_inverse   <= 1'b0;
            r_underline <= 1'b0;
            r_blank     <= 1'b0;
        end else if (w_accept) begin
            r_x         <= '0;
            r_y         <= '0;
            r_base      <= base_addr;
            r_shape     <= shape;
            r_fg        <= fg;
            r_bg        <= bg;
            r_inverse   <= attr_inverse;
            r_underline <= attr_underline;
            r_blank     <= attr_blank;
        end else if (w_advance) begin
            if (r_x != X_LAST) begin
                r_x <= r_x + XW'(1);
            end else begin
                r_x <= '0;
                r_y <= (r_y != Y_LAST) ? r_y + YW'(1) : '0;
            end
        end
    end

endmodule

// File: tb/tb_glyph_blit_engine.sv
// Scoreboard bench for glyph_blit_engine: a default-geometry instance and a
// 6x10 / 16-bit colour instance share one stimulus path selected by sel.
module tb_glyph_blit_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic         startA, startB;
    logic [19:0]  baseAddr;
    logic [127:0] shapeIn;
    logic [15:0]  fgIn, bgIn;
    logic         invIn, ulIn, blankIn;
    logic         ackIn;
    logic         sel;

    logic         vA, busyA, doneA, vB, busyB, doneB;
    logic [19:0]  addrA, addrB;
    logic [7:0]   dataA;
    logic [15:0]  dataB;
    logic         ackA, ackB;

    logic         obsValid, obsBusy, obsDone;
    logic [19:0]  obsAddr;
    logic [15:0]  obsData;

    int           checkCount = 0;
    int           errorCount = 0;
    logic [35:0]  expQ[$];
    int           gw, gh, stride;

    always #5 clk = ~clk;

    assign ackA     = sel ? 1'b0 : ackIn;
    assign ackB     = sel ? ackIn : 1'b0;
    assign obsValid = sel ? vB : vA;
    assign obsBusy  = sel ? busyB : busyA;
    assign obsDone  = sel ? doneB : doneA;
    assign obsAddr  = sel ? addrB : addrA;
    assign obsData  = sel ? dataB : {8'h00, dataA};

    glyph_blit_engine u_dutA (
        .clk(clk), .rst(rst), .start(startA), .base_addr(baseAddr), .shape(shapeIn),
        .fg(fgIn[7:0]), .bg(bgIn[7:0]), .attr_inverse(invIn), .attr_underline(ulIn),
        .attr_blank(blankIn), .req_valid(vA), .req_addr(addrA), .req_data(dataA),
        .req_ack(ackA), .busy(busyA), .done(doneA)
    );

    glyph_blit_engine #(
        .GLYPH_W(6), .GLYPH_H(10), .COLOR_W(16), .ADDR_W(20), .ROW_STRIDE(480)
    ) u_dutB (
        .clk(clk), .rst(rst), .start(startB), .base_addr(baseAddr), .shape(shapeIn[59:0]),
        .fg(fgIn), .bg(bgIn), .attr_inverse(invIn), .attr_underline(ulIn),
        .attr_blank(blankIn), .req_valid(vB), .req_addr(addrB), .req_data(dataB),
        .req_ack(ackB), .busy(busyB), .done(doneB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Pushes the full expected write sequence, then drives one cell and pops on each ack.
    task automatic applyStimulus(input logic [19:0] base, input logic [127:0] shp,
                                 input logic [15:0] fgv, input logic [15:0] bgv,
                                 input logic invv, input logic ulv, input logic blankv,
                                 input int stallIdx, input int stallLen,
                                 input int pulseCycle, input int pulseAtDone, input int abortAfter);
        int cycle, acks, stallLeft, expDone, extras;
        logic doneSeen, on;
        logic [31:0] a;
        logic [15:0] col;
        logic [35:0] front;
        for (int y = 0; y < gh; y++) begin
            for (int x = 0; x < gw; x++) begin
                on  = blankv ? 1'b0 : (shp[y*gw + x] | (ulv && (y == gh - 1)));
                col = (on ^ invv) ? fgv : bgv;
                a   = 32'(base) + 32'(y * stride + x);
                expQ.push_back({a[19:0], col});
            end
        end
        expDone = gw * gh + 1 + ((stallIdx < gw * gh) ? stallLen : 0);
        @(posedge clk); #1;
        baseAddr = base; shapeIn = shp; fgIn = fgv; bgIn = bgv;
        invIn = invv; ulIn = ulv; blankIn = blankv;
        ackIn = 1'b1;
        if (sel) startB = 1'b1; else startA = 1'b1;
        cycle = 0; acks = 0; stallLeft = stallLen; doneSeen = 1'b0;
        while (cycle < 400 && !doneSeen) begin
            @(posedge clk); #1;
            cycle++;
            startA = 1'b0; startB = 1'b0;
            if (cycle == 1) begin
                checkOutput("firstValid", 32'(obsValid), 32'd1);
                baseAddr = ~base; shapeIn = ~shp; fgIn = ~fgv; bgIn = ~bgv;
                invIn = ~invv; ulIn = ~ulv; blankIn = ~blankv;
            end
            if (cycle == pulseCycle) begin
                if (sel) startB = 1'b1; else startA = 1'b1;
            end
            if (abortAfter >= 0 && acks == abortAfter) begin
                rst = 1'b0;
                #1;
                checkOutput("rstValid", 32'(obsValid), 32'd0);
                checkOutput("rstBusy", 32'(obsBusy), 32'd0);
                checkOutput("rstDone", 32'(obsDone), 32'd0);
                checkOutput("rstAddr", 32'(obsAddr), 32'd0);
                checkOutput("rstData", 32'(obsData), 32'd0);
                @(posedge clk); #1;
                checkOutput("rstNoDone", 32'(obsDone), 32'd0);
                rst = 1'b1;
                expQ.delete();
                return;
            end
            if (obsDone) begin
                doneSeen = 1'b1;
                checkOutput("doneCycle", 32'(cycle), 32'(expDone));
                checkOutput("doneBusy", 32'(obsBusy), 32'd0);
                checkOutput("doneQueueEmpty", 32'(expQ.size()), 32'd0);
                if (pulseAtDone != 0) begin
                    if (sel) startB = 1'b1; else startA = 1'b1;
                end
            end else if (obsValid && expQ.size() > 0) begin
                front = expQ[0];
                if (acks == stallIdx && stallLeft > 0) begin
                    ackIn = 1'b0;
                    stallLeft--;
                    checkOutput("stallAddr", 32'(obsAddr), 32'(front[35:16]));
                end else begin
                    ackIn = 1'b1;
                    front = expQ.pop_front();
                    checkOutput("writeAddr", 32'(obsAddr), 32'(front[35:16]));
                    checkOutput("writeData", 32'(obsData), 32'(front[15:0]));
                    acks++;
                end
            end else if (obsValid) begin
                checkOutput("extraWrite", 32'(acks), 32'(gw * gh));
                ackIn = 1'b1;
            end
        end
        if (!doneSeen) checkOutput("doneTimeout", 32'(cycle), 32'(expDone));
        extras = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            startA = 1'b0; startB = 1'b0;
            if (obsDone || obsValid || obsBusy) extras++;
        end
        checkOutput("quietAfterDone", 32'(extras), 32'd0);
        expQ.delete();
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; startA = 1'b0; startB = 1'b0; ackIn = 1'b0;
        baseAddr = '0; shapeIn = '0; fgIn = '0; bgIn = '0;
        invIn = 1'b0; ulIn = 1'b0; blankIn = 1'b0;
        gw = 8; gh = 16; stride = 640;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetValid", 32'(obsValid), 32'd0);
        checkOutput("resetBusy", 32'(obsBusy), 32'd0);
        checkOutput("resetDone", 32'(obsDone), 32'd0);
        checkOutput("resetAddr", 32'(obsAddr), 32'd0);
        rst = 1'b1;

        applyStimulus(20'h00300, {$urandom, $urandom, $urandom, $urandom}, 16'h11, 16'h22,
                      1'b0, 1'b0, 1'b0, 999, 0, -1, 0, 5);
        applyStimulus(20'h00200, {$urandom, $urandom, $urandom, $urandom}, 16'h3C, 16'hC3,
                      1'b0, 1'b0, 1'b0, 999, 0, -1, 0, -1);
        applyStimulus(20'h00100, 128'h1, 16'hAA, 16'h55, 1'b0, 1'b0, 1'b0, 999, 0, -1, 0, -1);
        applyStimulus(20'h00100, 128'h1, 16'hAA, 16'h55, 1'b0, 1'b0, 1'b0, 7, 3, -1, 0, -1);
        applyStimulus(20'h01000, 128'h0, 16'hF0, 16'h0F, 1'b0, 1'b1, 1'b0, 999, 0, -1, 0, -1);
        applyStimulus(20'h01000, 128'h0, 16'hF0, 16'h0F, 1'b1, 1'b1, 1'b0, 999, 0, -1, 0, -1);
        applyStimulus(20'h01000, 128'h0, 16'hF0, 16'h0F, 1'b0, 1'b1, 1'b1, 999, 0, -1, 0, -1);
        applyStimulus(20'h02000, {128{1'b1}}, 16'h77, 16'h88, 1'b1, 1'b0, 1'b1, 999, 0, -1, 0, -1);
        applyStimulus(20'hFFFFF, {$urandom, $urandom, $urandom, $urandom}, 16'h5A, 16'hA5,
                      1'b0, 1'b1, 1'b0, 999, 0, 10, 1, -1);

        sel = 1'b1; gw = 6; gh = 10; stride = 480;
        applyStimulus(20'h04000, {$urandom, $urandom, $urandom, $urandom}, 16'hBEEF, 16'h1234,
                      1'b0, 1'b0, 1'b0, 999, 0, -1, 0, -1);
        applyStimulus(20'hFFF00, {$urandom, $urandom, $urandom, $urandom}, 16'hCAFE, 16'h0001,
                      1'b1, 1'b1, 1'b0, 20, 2, 5, 1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/glyph_blit_engine.md
Name: glyph_blit_engine

Overview:
- Parametrised successor of the per-character font renderer.
- Takes one character cell (glyph bitmap, foreground/background colours, attribute bits) on a start strobe and writes the cell into the SRAM framebuffer, one pixel per SRAM write, using a valid/ack handshake.
- Sits between the console text-layer scanner and the SRAM arbiter.
- Adds over the previous renderer: configurable cell and framebuffer geometry, explicit start/busy/done handshake, and inverse, underline and blank attributes.

Parameters:
- GLYPH_W, 8, pixels per glyph row (>=1)
- GLYPH_H, 16, glyph rows (>=1)
- COLOR_W, 8, bits per framebuffer pixel
- ADDR_W, 20, SRAM word address width
- ROW_STRIDE, 640, framebuffer words between vertically adjacent pixels

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to render a cell; sampled only in IDLE
- base_addr  in  ADDR_W  framebuffer address of the cell's top-left pixel
- shape  in  GLYPH_W*GLYPH_H  glyph bitmap; bit y*GLYPH_W+x is pixel (x,y); 1 = on
- fg  in  COLOR_W  foreground colour
- bg  in  COLOR_W  background colour
- attr_inverse  in  1  swap fg/bg for the whole cell
- attr_underline  in  1  force bottom row (y=GLYPH_H-1) on
- attr_blank  in  1  force every pixel off; overrides shape and underline
- req_valid  out  1  SRAM write request pending
- req_addr  out  ADDR_W  write address
- req_data  out  COLOR_W  write data
- req_ack  in  1  SRAM accepted/completed the current write
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last write is acked

Behaviour:
- Reset (rst=0, asynchronous, any state):
  - state=IDLE, x=y=0.
  - req_valid=0, busy=0, done=0; req_addr and req_data are 0.
  - Any in-flight write is abandoned; no done is produced.
- Operand capture: on start in IDLE, all inputs (base_addr, shape, fg, bg, attrs) are registered. Later input changes do not affect the cell being rendered.
- States:
  - IDLE: start=1 -> WRITE with x=y=0. Otherwise stay.
  - WRITE: req_valid=1, busy=1. Address and data stay stable until req_ack=1.
    - On ack: if x<GLYPH_W-1, x++.
    - Else x=0; if y<GLYPH_H-1, y++, else -> DONE.
    - Without ack: hold.
  - DONE: done=1, busy=0, req_valid=0 for exactly one cycle -> IDLE. start in DONE is ignored.
- start while busy is ignored (no queueing).
- req_ack is ignored when req_valid=0.
- Latency:
  - start in cycle 0 -> first req_valid in cycle 1.
  - With req_ack held high, done is in cycle GLYPH_W*GLYPH_H+1.
  - Back-to-back start is accepted in the cycle after done, so minimum cell period = GLYPH_W*GLYPH_H+2 cycles.
- Pixel function (registered attrs):
  - on = attr_blank ? 0 : (shape[y*GLYPH_W+x] | (attr_underline & y==GLYPH_H-1)).
  - colour = (on ^ attr_inverse) ? fg : bg.
  - blank+inverse gives a full fg cell.
- Address: req_addr = base_addr + y*ROW_STRIDE + x, computed at full precision and truncated modulo 2^ADDR_W (wrap-around permitted, no error).
- Write order is row-major: x fastest, one write per pixel, exactly GLYPH_W*GLYPH_H writes per cell.
- Counter widths: clog2(GLYPH_W) and clog2(GLYPH_H), minimum 1 bit each.

Test Plan:
- Reset mid-cell: start, ack 5 writes, assert rst=0 -> req_valid=0, busy=0, no done. After release, the next start begins at base_addr with x=y=0.
- Default params, base_addr=0x100, shape bit0=1 and all other bits 0, fg=0xAA, bg=0x55, req_ack always 1:
  - 128 writes, first to 0x100 with data 0xAA, second 0x101/0x55.
  - Write 9 to 0x100+640 (0x380).
  - done in cycle 129.
- Ack stall: hold req_ack=0 for 3 cycles on pixel (7,0) -> req_addr=0x107 stable, then 0x380 follows the ack. done is delayed by exactly 3 cycles.
- Attributes, shape=0:
  - underline -> only addrs base+15*640+0..7 carry fg.
  - underline+inverse -> those 8 carry bg, all others fg.
  - blank+underline -> all bg.
- Wrap and ignore: base_addr=0xFFFFF, ROW_STRIDE=640 -> second write to 0x00000. A start pulse at cycle 10 and at the done cycle are both ignored (exactly one done).
- Params GLYPH_W=6, GLYPH_H=10, ROW_STRIDE=480, COLOR_W=16: 60 writes. Last write to base+9*480+5. done in cycle 61.
